// File: rtl/sha256_compress.sv
// SHA-256 compression round engine: one round per accepted W word,
// then folds the working variables into the chaining state H0..H7.
module sha256_compress #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         first_block,
    input  logic         w_valid,
    input  logic [31:0]  w_data,
    output logic         w_ready,
    output logic         busy,
    output logic         done,
    output logic [255:0] digest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_DONE
    } state_t;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t         state_q, state_d;
    logic [5:0]     t_q, t_d;
    logic [255:0]   work_q, work_d;
    logic [255:0]   h_q, h_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [31:0] a, b, c, d, e, f, g, hh;
    logic [31:0] s0, s1, ch, maj, t1, t2;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] k_rom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;
            6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;
            6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;
            6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;
            6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;
            6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;
            6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;
            6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;
            6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;
            6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;
            6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;
            6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;
            6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;
            6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;
            6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;
            6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;
            6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;
            6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;
            6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;
            6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;
            6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;
            6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;
            6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;
            6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;
            6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;
            6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;
            6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;
            6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;
            6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;
            6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;
            6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;
            6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;
            default: k = 32'hc67178f2;
        endcase
        return k;
    endfunction

    assign {a, b, c, d, e, f, g, hh} = work_q;

    always_comb begin
        s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
        s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
        ch  = (e & f) ^ (~e & g);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t1  = hh + s1 + ch + k_rom(t_q) + w_data;
        t2  = s0 + maj;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (w_valid && t_q == LAST_T) state_d = S_FINAL;
            S_FINAL: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with it
    always_comb begin
        w_ready = (state_q == S_ROUND);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    always_comb begin
        work_d = work_q;
        t_d    = t_q;
        h_d    = h_q;
        case (state_q)
            S_IDLE: begin
                if (start && first_block) h_d = IV;
            end
            S_LOAD: begin
                work_d = h_q;
                t_d    = '0;
            end
            S_ROUND: begin
                if (w_valid) begin
                    work_d = {t1 + t2, a, b, c, d + t1, e, f, g};
                    t_d    = t_q + 6'd1;
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[32*i +: 32] = h_q[32*i +: 32] + work_q[32*i +: 32];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t_q    <= '0;
            work_q <= '0;
            h_q    <= IV;
        end else begin
            t_q    <= t_d;
            work_q <= work_d;
            h_q    <= h_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign digest = h_q;

endmodule
